// File: rtl/pio_ctrl_pkg.sv
// Shared constants for the extended PIO: register map, edge-capture modes,
// and the width helper for the pulse countdown.
package pio_ctrl_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_SET      = 3'd1;
    localparam logic [2:0] ADDR_CLR      = 3'd2;
    localparam logic [2:0] ADDR_TOG      = 3'd3;
    localparam logic [2:0] ADDR_IN       = 3'd4;
    localparam logic [2:0] ADDR_EDGE     = 3'd5;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd6;
    localparam logic [2:0] ADDR_PULSE    = 3'd7;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    // Counter must hold the full PULSE_CYCLES load value.
    function automatic int pulse_cnt_width(input int pulse_cycles);
        return $clog2(pulse_cycles + 1);
    endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// Input path: 2-FF synchroniser, previous-value flop and edge detector.
// Detect pulse appears two edges after an in_port change; no backpressure.
module pio_sync_edge
    import pio_ctrl_pkg::*;
#(
    parameter int W         = 32,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] in_port,
    output logic [W-1:0] sync_val,
    output logic [W-1:0] det
);

    logic [W-1:0] r_sync1;
    logic [W-1:0] r_sync2;
    logic [W-1:0] r_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign sync_val = r_sync2;

    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALL: det = ~r_sync2 & r_prev;
            EDGE_BOTH: det = r_sync2 ^ r_prev;
            default:   det = r_sync2 & ~r_prev;
        endcase
    end

endmodule

// File: rtl/pio_ctrl_ext.sv
// Avalon-MM PIO: atomic set/clear/toggle output register with timed pulses,
// edge-captured inputs and masked irq. readdata latency 1, no waitrequest.
module pio_ctrl_ext
    import pio_ctrl_pkg::*;
#(
    parameter int W            = 32,
    parameter int RESET_VALUE  = 58,
    parameter int PULSE_CYCLES = 16,
    parameter int EDGE_TYPE    = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [2:0]   address,
    input  logic         chipselect,
    input  logic         read_n,
    input  logic         write_n,
    input  logic [W-1:0] writedata,
    output logic [W-1:0] readdata,
    output logic [W-1:0] out_port,
    input  logic [W-1:0] in_port,
    output logic         irq
);

    localparam int            CW       = pulse_cnt_width(PULSE_CYCLES);
    localparam logic [W-1:0]  RST_DATA = W'(RESET_VALUE);
    localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_CYCLES);

    logic [W-1:0]  r_data_out;
    logic [W-1:0]  r_pulse_mask;
    logic [CW-1:0] r_pulse_cnt;
    logic [W-1:0]  r_readdata;
    logic [W-1:0]  r_edge_cap;
    logic [W-1:0]  r_irq_mask;
    logic          r_irq;

    logic          w_wr;
    logic          w_rd;
    logic          w_busy;
    logic          w_expire;
    logic [W-1:0]  w_sync_val;
    logic [W-1:0]  w_det;
    logic [W-1:0]  w_rd_mux;
    logic [W-1:0]  w_data_nxt;
    logic [W-1:0]  w_mask_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [W-1:0]  w_edge_clr;
    logic [W-1:0]  w_irq_mask_nxt;

    pio_sync_edge #(
        .W         (W),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .sync_val (w_sync_val),
        .det      (w_det)
    );

    assign w_wr     = chipselect & ~write_n;
    assign w_rd     = chipselect & ~read_n;
    assign w_busy   = (r_pulse_cnt != '0);
    assign w_expire = (r_pulse_cnt == CW'(1));

    // Expiry clear is applied first so a same-cycle bus write overrides it.
    always_comb begin
        w_data_nxt     = r_data_out;
        w_mask_nxt     = r_pulse_mask;
        w_cnt_nxt      = r_pulse_cnt;
        w_edge_clr     = '0;
        w_irq_mask_nxt = r_irq_mask;
        if (w_busy) begin
            w_cnt_nxt = r_pulse_cnt - CW'(1);
        end
        if (w_expire) begin
            w_data_nxt = r_data_out & ~r_pulse_mask;
            w_mask_nxt = '0;
        end
        if (w_wr) begin
            case (address)
                ADDR_DATA: w_data_nxt = writedata;
                ADDR_SET:  w_data_nxt = w_data_nxt | writedata;
                ADDR_CLR: begin
                    w_data_nxt = w_data_nxt & ~writedata;
                    w_mask_nxt = w_mask_nxt & ~writedata;
                end
                ADDR_TOG:      w_data_nxt = w_data_nxt ^ writedata;
                ADDR_EDGE:     w_edge_clr = writedata;
                ADDR_IRQ_MASK: w_irq_mask_nxt = writedata;
                ADDR_PULSE: begin
                    if ((writedata != '0) || w_busy) begin
                        w_data_nxt = w_data_nxt | writedata;
                        w_mask_nxt = w_mask_nxt | writedata;
                        w_cnt_nxt  = CNT_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:     w_rd_mux = r_data_out;
            ADDR_IN:       w_rd_mux = w_sync_val;
            ADDR_EDGE:     w_rd_mux = r_edge_cap;
            ADDR_IRQ_MASK: w_rd_mux = r_irq_mask;
            ADDR_PULSE:    w_rd_mux[0] = w_busy;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out   <= RST_DATA;
            r_pulse_mask <= '0;
            r_pulse_cnt  <= '0;
            r_readdata   <= '0;
            r_edge_cap   <= '0;
            r_irq_mask   <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_data_out   <= w_data_nxt;
            r_pulse_mask <= w_mask_nxt;
            r_pulse_cnt  <= w_cnt_nxt;
            r_irq_mask   <= w_irq_mask_nxt;
            if (w_rd) begin
                r_readdata <= w_rd_mux;
            end
            // New detections win over a same-cycle write-1-to-clear.
            r_edge_cap <= (r_edge_cap & ~w_edge_clr) | w_det;
            r_irq      <= |(r_edge_cap & r_irq_mask);
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_data_out;
    assign irq      = r_irq;

endmodule

// File: tb/tb_pio_ctrl_ext.sv
// Scoreboard bench for pio_ctrl_ext: directed register-map/pulse/edge/reset
// scenarios followed by randomized bus and input traffic.
module tb_pio_ctrl_ext;
    import pio_ctrl_pkg::*;

    localparam int W  = 32;
    localparam int RV = 58;
    localparam int PC = 4;

    logic          clk;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          read_n;
    logic          write_n;
    logic [W-1:0]  writedata;
    logic [W-1:0]  readdata;
    logic [W-1:0]  out_port;
    logic [W-1:0]  in_port;
    logic          irq;

    int checks = 0;
    int errors = 0;

    pio_ctrl_ext #(
        .W            (W),
        .RESET_VALUE  (RV),
        .PULSE_CYCLES (PC),
        .EDGE_TYPE    (0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .in_port    (in_port),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pulse tracked as an absolute expiry edge number,
    // inputs as a history of samples taken at each clock edge.
    int            n = 0;
    int            m_exp = -1;
    logic [31:0]   m_data, m_mask, m_edge, m_irqmask;
    logic          m_irq;
    logic [31:0]   inq[$];
    logic [31:0]   exp_q[$];
    logic          rd_seen = 1'b0;

    initial begin
        logic [31:0] e, s, p, clr;
        logic        busy;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_data    = 32'(RV);
                m_mask    = '0;
                m_edge    = '0;
                m_irqmask = '0;
                m_irq     = 1'b0;
                m_exp     = -1;
                inq       = '{32'h0, 32'h0, 32'h0};
                exp_q.delete();
                rd_seen   = 1'b0;
            end else begin
                n++;
                busy = (m_exp >= n);
                s    = inq[1];
                p    = inq[2];
                rd_seen = chipselect && !read_n;
                if (rd_seen) begin
                    case (address)
                        ADDR_DATA:     e = m_data;
                        ADDR_IN:       e = s;
                        ADDR_EDGE:     e = m_edge;
                        ADDR_IRQ_MASK: e = m_irqmask;
                        ADDR_PULSE:    e = {31'b0, busy};
                        default:       e = '0;
                    endcase
                    exp_q.push_back(e);
                end
                m_irq = |(m_edge & m_irqmask);
                if (m_exp == n) begin
                    m_data = m_data & ~m_mask;
                    m_mask = '0;
                end
                clr = '0;
                if (chipselect && !write_n) begin
                    case (address)
                        ADDR_DATA: m_data = writedata;
                        ADDR_SET:  m_data = m_data | writedata;
                        ADDR_CLR: begin
                            m_data = m_data & ~writedata;
                            m_mask = m_mask & ~writedata;
                        end
                        ADDR_TOG:      m_data = m_data ^ writedata;
                        ADDR_EDGE:     clr = writedata;
                        ADDR_IRQ_MASK: m_irqmask = writedata;
                        ADDR_PULSE: begin
                            if (writedata != 0 || busy) begin
                                m_data = m_data | writedata;
                                m_mask = m_mask | writedata;
                                m_exp  = n + PC;
                            end
                        end
                        default: ;
                    endcase
                end
                m_edge = (m_edge & ~clr) | (s & ~p);
                inq.push_front(in_port);
                void'(inq.pop_back());
            end
        end
    end

    // Monitor: outputs compared every cycle, readdata whenever a read completes.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                check("out_port", out_port, m_data);
                check("irq", {31'b0, irq}, {31'b0, m_irq});
                if (rd_seen) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL readdata: read completed with no expected entry at %0t", $time);
                    end else begin
                        check("readdata", readdata, exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic op(input bit rd, input bit wr, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        read_n     = !rd;
        write_n    = !wr;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        in_port    = '0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        check("reset_out_port", out_port, 32'h0000_003A);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);

        op(1, 0, ADDR_DATA, 0);
        check("data_read_rv", readdata, 32'h3A);

        // Atomic register writes.
        op(0, 1, ADDR_DATA, 32'hF0); check("seq_data", out_port, 32'hF0);
        op(0, 1, ADDR_SET,  32'h0F); check("seq_set",  out_port, 32'hFF);
        op(0, 1, ADDR_CLR,  32'h30); check("seq_clr",  out_port, 32'hCF);
        op(0, 1, ADDR_TOG,  32'h81); check("seq_tog",  out_port, 32'h4E);
        for (int a = 1; a <= 3; a++) op(1, 0, 3'(a), 0);

        // Single pulse: high on edges E..E+3, low at E+4.
        op(0, 1, ADDR_DATA, 0);
        op(0, 1, ADDR_PULSE, 1);
        check("pulse_E", out_port, 32'h1);
        op(1, 0, ADDR_PULSE, 0);
        op(1, 0, ADDR_PULSE, 0);
        op(1, 0, ADDR_PULSE, 0);
        check("pulse_E3", out_port, 32'h1);
        op(1, 0, ADDR_PULSE, 0);
        check("pulse_E4", out_port, 32'h0);
        op(1, 0, ADDR_PULSE, 0);
        check("pulse_idle_read", readdata, 32'h0);

        // Zero PULSE write while idle is ignored.
        op(0, 1, ADDR_PULSE, 0);
        op(1, 0, ADDR_PULSE, 0);

        // Retrigger at E+2 merges masks; both clear at E+6.
        op(0, 1, ADDR_PULSE, 1);
        @(posedge clk);
        op(0, 1, ADDR_PULSE, 2);
        repeat (3) begin
            @(posedge clk); #1;
            check("retrig_hold", out_port & 32'h3, 32'h3);
        end
        @(posedge clk); #1;
        check("retrig_clear", out_port & 32'h3, 32'h0);

        // Rising edge capture and irq.
        op(0, 1, ADDR_IRQ_MASK, 32'h4);
        @(negedge clk) in_port = 32'h4;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        check("irq_before", {31'b0, irq}, 32'h0);
        @(posedge clk); #1;
        check("irq_after", {31'b0, irq}, 32'h1);
        op(1, 0, ADDR_EDGE, 0);
        check("edge_cap", readdata, 32'h4);
        op(0, 1, ADDR_EDGE, 32'h4);
        @(posedge clk); #1;
        check("irq_cleared", {31'b0, irq}, 32'h0);

        // New rising edge detected in the same cycle as the clear.
        @(negedge clk) in_port = 32'h0;
        repeat (4) @(posedge clk);
        @(negedge clk) in_port = 32'h4;
        @(posedge clk);
        @(posedge clk);
        op(0, 1, ADDR_EDGE, 32'h4);
        op(1, 0, ADDR_EDGE, 0);
        check("edge_set_wins", readdata, 32'h4);

        // Expiry coincident with a DATA write: bus wins.
        op(0, 1, ADDR_DATA, 0);
        op(0, 1, ADDR_PULSE, 1);
        op(1, 0, ADDR_PULSE, 0);
        op(1, 0, ADDR_PULSE, 0);
        op(1, 0, ADDR_PULSE, 0);
        op(0, 1, ADDR_DATA, 1);
        check("expiry_vs_data", out_port, 32'h1);
        op(1, 0, ADDR_PULSE, 0);
        check("expiry_busy", readdata, 32'h0);

        // Reset mid-pulse: no resumed pulse and no late clear.
        op(0, 1, ADDR_PULSE, 32'h2);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check("reset_async", out_port, 32'h3A);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        op(1, 0, ADDR_PULSE, 0);
        check("reset_busy", readdata, 32'h0);
        repeat (6) @(posedge clk);
        #1 check("reset_no_resume", out_port, 32'h3A);

        // Randomized traffic against the model.
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) in_port = in_port ^ (32'h1 << $urandom_range(0, 31));
            chipselect = ($urandom_range(0, 5) != 0);
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
            case ($urandom_range(0, 3))
                0: writedata = writedata & 32'hFF;
                1: writedata = 32'h1 << $urandom_range(0, 31);
                2: if ($urandom_range(0, 3) == 0) writedata = '0;
                default: ;
            endcase
            read_n  = 1'b1;
            write_n = 1'b1;
            case ($urandom_range(0, 2))
                0: read_n  = 1'b0;
                1: write_n = 1'b0;
                default: ;
            endcase
        end
        @(negedge clk);
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pio_ctrl_ext.md
Name: pio_ctrl_ext

Overview:
Parametrised Avalon-MM parallel I/O block, the next generation of the system's simple output-register PIO.
- Output side: W-bit output port with a programmable reset value, atomic set/clear/toggle writes, and a self-clearing pulse mode driven by a shared countdown timer.
- Input side: W-bit input port with a 2-FF synchroniser, configurable edge capture and a masked, level interrupt.
- Sits on the Qsys/system interconnect, driving pulser/front-end control lines and sampling status lines.

Parameters:
W, 32, data width of out_port/in_port/readdata/writedata (1..32)
RESET_VALUE, 58, reset value of the output register (low W bits used)
PULSE_CYCLES, 16, pulse high time in clk cycles (>=1)
EDGE_TYPE, 0, edge capture mode: 0 rising, 1 falling, 2 both

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
address  in  3  word address
chipselect  in  1  slave select
read_n  in  1  active-low read strobe
write_n  in  1  active-low write strobe
writedata  in  W  write data
readdata  out  W  registered read data, fixed latency 1
out_port  out  W  output register
in_port  in  W  asynchronous input lines
irq  out  1  registered interrupt, active high

Behaviour:
- Reset values (reset_n low, asynchronous):
  - data_out = RESET_VALUE; out_port = data_out.
  - readdata, edge_cap, irq_mask, pulse_mask, pulse_cnt, irq and synchroniser/edge flops = 0.
- A write is accepted on a rising edge with chipselect=1 and write_n=0. A read is the same with read_n=0.
- Address map:
  - 0 DATA: write data_out<=wd; read data_out.
  - 1 SET: data_out |= wd; read 0.
  - 2 CLR: data_out &= ~wd, and pulse_mask &= ~wd; read 0.
  - 3 TOG: data_out ^= wd; read 0.
  - 4 IN: read-only, returns synchronised in_port; write ignored.
  - 5 EDGE: read edge_cap; write-1-to-clear.
  - 6 IRQ_MASK: read/write.
  - 7 PULSE:
    - Write: data_out |= wd; pulse_mask |= wd; pulse_cnt <= PULSE_CYCLES. A write of 0 only reloads the count when busy; it is ignored when idle.
    - Read: bit0 = busy (pulse_cnt != 0), other bits 0.
- Pulse timing:
  - pulse_cnt decrements every cycle while nonzero.
  - On the edge where pulse_cnt goes 1->0: data_out &= ~pulse_mask; pulse_mask <= 0.
  - A PULSE write on edge E gives the written bits high for exactly PULSE_CYCLES cycles.
- Retrigger while busy: masks merge and the count reloads; all pulsed bits then clear together at the new expiry.
- Expiry coinciding with a bus write: expiry clear is applied first, then the bus write (bus wins).
  - A PULSE write in the expiry cycle reloads the count and pulse_mask = wd only.
- DATA/SET/TOG writes during a pulse do not alter pulse_mask; pulsed bits still clear at expiry.
- Read latency: readdata is loaded on the accepting edge and valid the following cycle. It holds its value when no read is accepted. Unused bits read 0.
- Input path:
  - in_port passes through 2 FFs (sync), then a 3rd FF (prev).
  - Edge detect: rise = sync&~prev; fall = ~sync&prev; both = sync^prev. Latency from in_port change to edge_cap set is 3 edges.
  - edge_cap |= det. Write-1-to-clear on EDGE; if detect and clear hit the same bit in the same cycle, set wins.
- irq <= |(edge_cap & irq_mask), registered, with one cycle of latency after edge_cap/irq_mask change.
- Reset asserted mid-pulse: immediate return to reset values. No pulse resumes and no residual clear is applied after release.

Decomposition:
- Package pio_ctrl_pkg holds:
  - Address constants ADDR_DATA..ADDR_PULSE (3-bit).
  - EDGE_RISE/EDGE_FALL/EDGE_BOTH constants.
  - A counter-width function clog2(PULSE_CYCLES+1).
- Sub-module pio_sync_edge, parametrised by W and EDGE_TYPE: synchroniser + prev FF + edge detect. Inputs clk, reset_n, in_port. Outputs sync_val[W] and det[W].
- The top level holds the register file, pulse timer, read mux and irq.

Test Plan:
- Reset with RESET_VALUE=58, W=32 -> out_port=0x0000003A, readdata=0, irq=0. DATA read returns 0x3A one cycle after the read edge.
- DATA write 0xF0, SET 0x0F, CLR 0x30, TOG 0x81 -> out_port sequence 0xF0, 0xFF, 0xCF, 0x4E.
- PULSE_CYCLES=4, data_out=0, PULSE write 0x1 on edge E:
  - bit0 high on edges E..E+3, low at E+4.
  - PULSE read returns 1 during the pulse, 0 after.
  - Retrigger with 0x2 at E+2 -> bits0,1 both clear at E+6.
- EDGE_TYPE=0, irq_mask=0x4, in_port bit2 0->1:
  - edge_cap=0x4 after 3 edges, irq=1 one edge later.
  - EDGE write 0x4 clears both. A new rising edge coincident with the clear leaves edge_cap=0x4.
- Expiry coincident with a DATA write of 0x1 (bit pulsed) -> data_out=0x1 after the edge, busy=0.
- reset_n asserted at E+1 of a 4-cycle pulse -> out_port=RESET_VALUE immediately, busy=0 after release, no further change.
